// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the main-memory responder.
// Imported by the responder FSM and its RAM.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 16;
   localparam int LAT_CNT_W  = 4;

   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM with registered read port.
// Storage is never reset; only the read register is.
module mem_responder_mem_array
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              CLK,
   input  logic              CLR_N,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge CLK) begin
      if (en && we == WR) begin
         mem[addr] <= wdata;
      end
   end

   // Read register holds its value between read commits.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         rdata <= '0;
      end else if (en && we == RD) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Far-end memory responder: REQ/ACK handshake, programmable
// wait latency, single-word reads and writes.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LAT    = 2
) (
   input  logic              CLK,
   input  logic              CLR_N,
   input  logic              REQ,
   input  logic              WE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] WDATA,
   output logic              ACK,
   output logic [DATA_W-1:0] RDATA,
   output logic              BUSY
);

   localparam logic [LAT_CNT_W-1:0] LAT_V = LAT_CNT_W'(LAT);

   state_t               state;
   logic [LAT_CNT_W-1:0] cnt;
   logic                 we_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic                 commit;

   assign commit = (state == WAIT) && (cnt == '0);

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= RD;
         addr_q  <= '0;
         wdata_q <= '0;
         ACK     <= 1'b0;
         BUSY    <= 1'b0;
      end else begin
         ACK <= 1'b0;
         unique case (state)
            IDLE: begin
               if (REQ) begin
                  state   <= WAIT;
                  cnt     <= LAT_V;
                  we_q    <= WE;
                  addr_q  <= ADDR;
                  wdata_q <= WDATA;
                  BUSY    <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= RESP;
                  ACK   <= 1'b1;
               end
            end
            RESP: begin
               // A REQ still held here is a fresh request.
               if (REQ) begin
                  state   <= WAIT;
                  cnt     <= LAT_V;
                  we_q    <= WE;
                  addr_q  <= ADDR;
                  wdata_q <= WDATA;
               end else begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

   mem_responder_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .en    (commit),
      .we    (we_q),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (RDATA)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LAT=2 and one LAT=0
// instance sharing a clock.
module tb_mem_responder;

   logic        CLK;
   logic        CLR_N;

   logic        req2, we2, ack2, busy2;
   logic [11:0] addr2;
   logic [15:0] wdata2, rdata2;

   logic        req0, we0, ack0, busy0;
   logic [11:0] addr0;
   logic [15:0] wdata0, rdata0;

   int nvec;
   int nerr;

   mem_responder #(.ADDR_W(12), .DATA_W(16), .LAT(2)) dut2 (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .REQ   (req2),
      .WE    (we2),
      .ADDR  (addr2),
      .WDATA (wdata2),
      .ACK   (ack2),
      .RDATA (rdata2),
      .BUSY  (busy2)
   );

   mem_responder #(.ADDR_W(12), .DATA_W(16), .LAT(0)) dut0 (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .REQ   (req0),
      .WE    (we0),
      .ADDR  (addr0),
      .WDATA (wdata0),
      .ACK   (ack0),
      .RDATA (rdata0),
      .BUSY  (busy0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic logic ack_of(input bit s);
      return s ? ack0 : ack2;
   endfunction

   function automatic logic busy_of(input bit s);
      return s ? busy0 : busy2;
   endfunction

   function automatic logic [15:0] rd_of(input bit s);
      return s ? rdata0 : rdata2;
   endfunction

   task automatic drive(input bit s, input logic r, input logic w,
                        input logic [11:0] a, input logic [15:0] d);
      if (s) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req2 = r; we2 = w; addr2 = a; wdata2 = d;
      end
   endtask

   // Issue one request; lat = edges from acceptance to the ACK edge.
   task automatic xfer(input bit s, input logic w,
                       input logic [11:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd);
      @(negedge CLK);
      drive(s, 1'b1, w, a, d);
      @(posedge CLK);
      #1;
      drive(s, 1'b0, 1'b0, 12'h000, 16'h0000);
      lat = -1;
      rd  = 16'h0000;
      for (int j = 1; j <= 20; j++) begin
         @(posedge CLK);
         #1;
         if (ack_of(s)) begin
            lat = j;
            rd  = rd_of(s);
            break;
         end
      end
   endtask

   task automatic count_acks(input bit s, input int n, output int c);
      c = 0;
      for (int j = 0; j < n; j++) begin
         @(posedge CLK);
         #1;
         if (ack_of(s)) c++;
      end
   endtask

   task automatic do_reset;
      @(negedge CLK);
      CLR_N = 1'b0;
      repeat (3) @(negedge CLK);
      CLR_N = 1'b1;
   endtask

   int          lat;
   int          c;
   logic [15:0] rd;

   initial begin
      nvec  = 0;
      nerr  = 0;
      CLR_N = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000);

      // Reset state
      do_reset();
      #1;
      chk("rst_ack", 32'(ack2), 32'h0);
      chk("rst_busy", 32'(busy2), 32'h0);
      chk("rst_rdata", 32'(rdata2), 32'h0);
      chk("rst_rdata0", 32'(rdata0), 32'h0);
      count_acks(1'b0, 6, c);
      chk("idle_no_ack", 32'(c), 32'd0);

      // Write then read, LAT=2
      xfer(1'b0, 1'b1, 12'h123, 16'hBEEF, lat, rd);
      chk("wr_lat", 32'(lat), 32'd3);
      chk("wr_rdata", 32'(rd), 32'h0000);
      chk("wr_busy_ack", 32'(busy2), 32'h1);
      @(posedge CLK);
      #1;
      chk("wr_ack_1cyc", 32'(ack2), 32'h0);
      chk("wr_busy_off", 32'(busy2), 32'h0);
      xfer(1'b0, 1'b0, 12'h123, 16'h0000, lat, rd);
      chk("rd_lat", 32'(lat), 32'd3);
      chk("rd_data", 32'(rd), 32'hBEEF);

      // LAT=0 preload, then back-to-back reads with REQ held
      xfer(1'b1, 1'b1, 12'h000, 16'h1111, lat, rd);
      chk("l0_wr0_lat", 32'(lat), 32'd1);
      xfer(1'b1, 1'b1, 12'h001, 16'h2222, lat, rd);
      chk("l0_wr1_lat", 32'(lat), 32'd1);
      @(negedge CLK);
      drive(1'b1, 1'b1, 1'b0, 12'h000, 16'h0000);
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      chk("b2b_ack1", 32'(ack0), 32'h1);
      chk("b2b_rd1", 32'(rdata0), 32'h1111);
      addr0 = 12'h001;
      @(posedge CLK);
      #1;
      chk("b2b_gap", 32'(ack0), 32'h0);
      chk("b2b_gap_busy", 32'(busy0), 32'h1);
      @(posedge CLK);
      #1;
      chk("b2b_ack2", 32'(ack0), 32'h1);
      chk("b2b_rd2", 32'(rdata0), 32'h2222);
      req0 = 1'b0;
      @(posedge CLK);
      #1;
      chk("b2b_idle", 32'(busy0), 32'h0);

      // Ignore REQ while busy
      xfer(1'b0, 1'b1, 12'h010, 16'h1234, lat, rd);
      xfer(1'b0, 1'b1, 12'h020, 16'h5678, lat, rd);
      @(negedge CLK);
      drive(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000);
      @(posedge CLK);
      #1;
      drive(1'b0, 1'b1, 1'b1, 12'h020, 16'hDEAD);
      c = 0;
      @(posedge CLK);
      #1;
      if (ack2) c++;
      req2 = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(posedge CLK);
         #1;
         if (ack2) begin
            c++;
            chk("busy_rd", 32'(rdata2), 32'h1234);
         end
      end
      chk("busy_one_ack", 32'(c), 32'd1);
      xfer(1'b0, 1'b0, 12'h020, 16'h0000, lat, rd);
      chk("busy_no_wr", 32'(rd), 32'h5678);

      // Abort a write one cycle after acceptance
      xfer(1'b0, 1'b1, 12'h055, 16'h3333, lat, rd);
      @(negedge CLK);
      drive(1'b0, 1'b1, 1'b1, 12'h055, 16'hCAFE);
      @(posedge CLK);
      #1;
      drive(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
      @(posedge CLK);
      #1;
      CLR_N = 1'b0;
      #1;
      chk("abort_busy", 32'(busy2), 32'h0);
      chk("abort_ack", 32'(ack2), 32'h0);
      @(negedge CLK);
      @(negedge CLK);
      CLR_N = 1'b1;
      count_acks(1'b0, 6, c);
      chk("abort_no_ack", 32'(c), 32'd0);
      xfer(1'b0, 1'b0, 12'h055, 16'h0000, lat, rd);
      chk("abort_mem", 32'(rd), 32'h3333);

      // Memory survives reset
      xfer(1'b0, 1'b1, 12'hFFF, 16'h0F0F, lat, rd);
      do_reset();
      #1;
      chk("persist_rst", 32'(rdata2), 32'h0);
      xfer(1'b0, 1'b0, 12'hFFF, 16'h0000, lat, rd);
      chk("persist_lat", 32'(lat), 32'd3);
      chk("persist_rd", 32'(rd), 32'h0F0F);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
